// File: rtl/pc_pkg.sv
// pc_pkg: shared fetch-FSM state encoding and default reset/trap addresses for njesia_pc.
package pc_pkg;
  typedef enum logic [1:0] {NIS = 2'b00, KERKO = 2'b01, MBAJ = 2'b10} state_t;
  localparam logic [23:0] DEF_RESET_ADDR = 24'h000000;
  localparam logic [23:0] DEF_TRAP_ADDR  = 24'h000010;
endpackage

// File: rtl/zgjedhja_pc.sv
// zgjedhja_pc: next-PC priority select, jump over (branch over PC+1), from two 2:1 selectors.
module mux2 #(
  parameter int WIDTH = 24
) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_sel ? i_d1 : i_d0;
endmodule

module zgjedhja_pc #(
  parameter int WIDTH = 24
) (
  input  logic             i_kerce,
  input  logic [WIDTH-1:0] i_adresa_kercimit,
  input  logic             i_dega,
  input  logic [WIDTH-1:0] i_adresa_deges,
  input  logic [WIDTH-1:0] i_pc_plus1,
  output logic [WIDTH-1:0] o_pc_next
);
  logic [WIDTH-1:0] w_branch;
  mux2 #(.WIDTH(WIDTH)) u_dega  (.i_sel(i_dega),  .i_d0(i_pc_plus1), .i_d1(i_adresa_deges),    .o_y(w_branch));
  mux2 #(.WIDTH(WIDTH)) u_kerce (.i_sel(i_kerce), .i_d0(w_branch),   .i_d1(i_adresa_kercimit), .o_y(o_pc_next));
endmodule

// File: rtl/njesia_pc.sv
// njesia_pc: program counter and instruction fetch FSM (NIS -> KERKO -> MBAJ).
// Optional PC_TRAP_EN macro redirects out-of-range next-PC to TRAP_ADDR and sets sticky Gabim.
module njesia_pc
  import pc_pkg::*;
#(
  parameter int               WIDTH      = 24,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(DEF_RESET_ADDR),
  parameter logic [WIDTH-1:0] TRAP_ADDR  = WIDTH'(DEF_TRAP_ADDR),
  parameter int               MEM_DEPTH  = 4096
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Vazhdo,
  input  logic             Stall,
  input  logic             Dega,
  input  logic [WIDTH-1:0] AdresaDeges,
  input  logic             Kerce,
  input  logic [WIDTH-1:0] AdresaKercimit,
  output logic             Kerko,
  input  logic             Gati,
  input  logic [WIDTH-1:0] TeDhenat,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCplus1,
  output logic [WIDTH-1:0] Instruksioni,
  output logic             Valid,
  output logic             Gabim
);
`ifdef PC_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_pc, r_instr, w_sel, w_pc_next;
  logic             r_gabim, w_adv, w_trap;
  assign PC           = r_pc;
  assign PCplus1      = r_pc + WIDTH'(1);
  assign Instruksioni = r_instr;
  assign Gabim        = TRAP_EN & r_gabim;
  assign w_adv        = (r_state == MBAJ) && Vazhdo && !Stall;
  zgjedhja_pc #(.WIDTH(WIDTH)) u_zgjedhja (
    .i_kerce          (Kerce),
    .i_adresa_kercimit(AdresaKercimit),
    .i_dega           (Dega),
    .i_adresa_deges   (AdresaDeges),
    .i_pc_plus1       (PCplus1),
    .o_pc_next        (w_sel)
  );
  assign w_trap    = TRAP_EN && (w_sel >= WIDTH'(MEM_DEPTH));
  assign w_pc_next = w_trap ? TRAP_ADDR : w_sel;
  always_comb begin
    w_next = r_state == NIS   ? KERKO :
             r_state == KERKO ? (Gati ? MBAJ : KERKO) :
             r_state == MBAJ  ? (w_adv ? KERKO : MBAJ) : NIS;
    Kerko  = r_state == KERKO;
    Valid  = r_state == MBAJ;
  end
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= NIS;
      r_pc    <= RESET_ADDR;
      r_instr <= '0;
      r_gabim <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_adv) r_pc <= w_pc_next;
      if (w_adv && w_trap) r_gabim <= 1'b1;
      if (r_state == KERKO && Gati) r_instr <= TeDhenat;
    end
  end
endmodule

// File: tb/tb_njesia_pc.sv
// tb_njesia_pc: table-driven vectors plus hand sequences for wrap/trap and mid-fetch reset.
module tb_njesia_pc;
  logic        clk = 1'b0, rst_n;
  logic        vazhdo, stall, dega, kerce, gati;
  logic [23:0] ad_deges, ad_kercimit, te_dhenat;
  logic        kerko, valid, gabim;
  logic [23:0] pc, pc_plus1, instr;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic gati; logic [23:0] data;
    logic vaz, stall, dega; logic [23:0] ad;
    logic kerce; logic [23:0] ak;
    logic [23:0] e_pc, e_instr; logic e_valid, e_kerko;
  } vec_t;

  typedef struct {
    string name;
    logic [23:0] pc, instr;
    logic valid, kerko, gabim;
  } exp_t;

  exp_t q[$];
  vec_t v[12];

  always #5 clk = ~clk;

  njesia_pc dut (
    .Clock(clk), .Reset_n(rst_n), .Vazhdo(vazhdo), .Stall(stall),
    .Dega(dega), .AdresaDeges(ad_deges), .Kerce(kerce), .AdresaKercimit(ad_kercimit),
    .Kerko(kerko), .Gati(gati), .TeDhenat(te_dhenat),
    .PC(pc), .PCplus1(pc_plus1), .Instruksioni(instr), .Valid(valid), .Gabim(gabim)
  );

  function automatic vec_t mk(logic g, logic [23:0] d, logic vz, logic st, logic dg, logic [23:0] a,
                              logic kc, logic [23:0] k, logic [23:0] ep, logic [23:0] ei, logic ev, logic ek);
    vec_t r;
    r.gati = g; r.data = d; r.vaz = vz; r.stall = st; r.dega = dg; r.ad = a;
    r.kerce = kc; r.ak = k; r.e_pc = ep; r.e_instr = ei; r.e_valid = ev; r.e_kerko = ek;
    return r;
  endfunction

  task automatic drive(logic g, logic [23:0] d, logic vz, logic st, logic dg, logic [23:0] a,
                       logic kc, logic [23:0] k);
    gati = g; te_dhenat = d; vazhdo = vz; stall = st; dega = dg; ad_deges = a; kerce = kc; ad_kercimit = k;
  endtask

  task automatic push(string n, logic [23:0] p, logic [23:0] i, logic va, logic ke, logic ga);
    exp_t e;
    e.name = n; e.pc = p; e.instr = i; e.valid = va; e.kerko = ke; e.gabim = ga;
    q.push_back(e);
  endtask

  task automatic cmp(string n, string f, logic [23:0] act, logic [23:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got %h, expected %h", n, f, act, req);
    end
  endtask

  task automatic check();
    exp_t e;
    logic [23:0] p1;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: no expectation queued");
      return;
    end
    e = q.pop_front();
    p1 = e.pc + 24'd1;
    cmp(e.name, "PC", pc, e.pc);
    cmp(e.name, "PCplus1", pc_plus1, p1);
    cmp(e.name, "Instruksioni", instr, e.instr);
    cmp(e.name, "Valid", {23'd0, valid}, {23'd0, e.valid});
    cmp(e.name, "Kerko", {23'd0, kerko}, {23'd0, e.kerko});
    cmp(e.name, "Gabim", {23'd0, gabim}, {23'd0, e.gabim});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    v[0]  = mk(0, 24'h0,      0, 0, 0, 24'h0,   0, 24'h0,   24'h000000, 24'h000000, 0, 1);
    v[1]  = mk(1, 24'hABCDEF, 0, 0, 0, 24'h0,   0, 24'h0,   24'h000000, 24'hABCDEF, 1, 0);
    v[2]  = mk(0, 24'h0,      1, 0, 1, 24'h100, 1, 24'h200, 24'h000200, 24'hABCDEF, 0, 1);
    v[3]  = mk(0, 24'h0,      1, 0, 0, 24'h0,   0, 24'h0,   24'h000200, 24'hABCDEF, 0, 1);
    v[4]  = mk(1, 24'h123456, 0, 0, 0, 24'h0,   0, 24'h0,   24'h000200, 24'h123456, 1, 0);
    v[5]  = mk(1, 24'h999999, 1, 1, 0, 24'h0,   1, 24'h500, 24'h000200, 24'h123456, 1, 0);
    v[6]  = mk(0, 24'h0,      0, 0, 1, 24'h300, 0, 24'h0,   24'h000200, 24'h123456, 1, 0);
    v[7]  = mk(0, 24'h0,      1, 0, 0, 24'h0,   0, 24'h0,   24'h000201, 24'h123456, 0, 1);
    v[8]  = mk(1, 24'h0000AA, 0, 0, 0, 24'h0,   0, 24'h0,   24'h000201, 24'h0000AA, 1, 0);
    v[9]  = mk(0, 24'h0,      1, 0, 1, 24'h400, 0, 24'h0,   24'h000400, 24'h0000AA, 0, 1);
    v[10] = mk(0, 24'h555555, 0, 0, 0, 24'h0,   0, 24'h0,   24'h000400, 24'h0000AA, 0, 1);
    v[11] = mk(1, 24'h111111, 0, 0, 0, 24'h0,   0, 24'h0,   24'h000400, 24'h111111, 1, 0);

    rst_n = 1'b0;
    drive(1, 24'hDEAD00, 1, 0, 1, 24'h42, 1, 24'h43);
    #3;
    push("reset", 24'h0, 24'h0, 0, 0, 0);
    check();
    @(posedge clk);
    @(posedge clk);
    #2;
    drive(0, 24'h0, 0, 0, 0, 24'h0, 0, 24'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(v[i].gati, v[i].data, v[i].vaz, v[i].stall, v[i].dega, v[i].ad, v[i].kerce, v[i].ak);
      push($sformatf("vec%0d", i), v[i].e_pc, v[i].e_instr, v[i].e_valid, v[i].e_kerko, 0);
      step();
    end

`ifdef PC_TRAP_EN
    drive(0, 24'h0, 1, 0, 0, 24'h0, 1, 24'h001000);
    push("trap_jump", 24'h000010, 24'h111111, 0, 1, 1);
    step();
    drive(1, 24'h222222, 0, 0, 0, 24'h0, 0, 24'h0);
    push("trap_fetch", 24'h000010, 24'h222222, 1, 0, 1);
    step();
    drive(0, 24'h0, 1, 0, 0, 24'h0, 0, 24'h0);
    push("trap_sticky", 24'h000011, 24'h222222, 0, 1, 1);
    step();
`else
    drive(0, 24'h0, 1, 0, 0, 24'h0, 1, 24'hFFFFFF);
    push("jump_top", 24'hFFFFFF, 24'h111111, 0, 1, 0);
    step();
    drive(1, 24'h222222, 0, 0, 0, 24'h0, 0, 24'h0);
    push("fetch_top", 24'hFFFFFF, 24'h222222, 1, 0, 0);
    step();
    drive(0, 24'h0, 1, 0, 0, 24'h0, 0, 24'h0);
    push("wrap", 24'h000000, 24'h222222, 0, 1, 0);
    step();
`endif

    drive(1, 24'h777777, 0, 0, 0, 24'h0, 0, 24'h0);
    rst_n = 1'b0;
    #1;
    push("rst_async", 24'h0, 24'h0, 0, 0, 0);
    check();
    @(posedge clk);
    @(posedge clk);
    #1;
    push("rst_hold", 24'h0, 24'h0, 0, 0, 0);
    check();
    #2;
    rst_n = 1'b1;
    push("rst_nis", 24'h0, 24'h0, 0, 1, 0);
    step();
    push("rst_refetch", 24'h0, 24'h777777, 1, 0, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
